// File: rtl/synth_sample_trig_pkg.sv
// Shared types and helpers for the sample-trigger generator.
// Holds the lock/frame state encodings and the ceil-log2 helper used to size counters.
package synth_sample_trig_pkg;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } frame_state_e;

  localparam int OVR_CNT_W = 16;

  // Returns ceil(log2(value)), never less than 1 so it can size a vector directly.
  function automatic int clogb2(input longint unsigned value);
    int width;
    longint unsigned v;
    width = 0;
    v = (value > 1) ? value - 1 : 0;
    while (v != 0) begin
      width++;
      v = v >> 1;
    end
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/synth_sample_trig_if.sv
// Control/status bundle of the sample-trigger generator.
// trig is a fire-and-forget pulse with no ready/backpressure; the engine must accept it as issued.
interface synth_sample_trig_if;
  import synth_sample_trig_pkg::*;

  logic                 lrck_in;
  logic                 lock_en;
  logic                 xxxx_zero;
  logic                 clr_stat;
  logic                 trig;
  logic                 lrck_locked;
  logic                 frame_busy;
  logic                 overrun;
  logic [OVR_CNT_W-1:0] overrun_cnt;
  lock_state_e          dbg_lock_state;
  frame_state_e         dbg_frame_state;

  modport master (
    output lrck_in, lock_en, xxxx_zero, clr_stat,
    input  trig, lrck_locked, frame_busy, overrun, overrun_cnt,
    input  dbg_lock_state, dbg_frame_state
  );

  modport slave (
    input  lrck_in, lock_en, xxxx_zero, clr_stat,
    output trig, lrck_locked, frame_busy, overrun, overrun_cnt,
    output dbg_lock_state, dbg_frame_state
  );

endinterface

// File: rtl/synth_sample_trig_frac_tick_div.sv
// Fractional phase-accumulator divider: one-cycle tick at SAMPLE_RATE out of AUDIO_CLK_RATE.
// Free-running from reset so any consumer switching onto it stays phase-continuous.
module frac_tick_div
  import synth_sample_trig_pkg::*;
#(
  parameter int AUDIO_CLK_RATE = 90416666,
  parameter int SAMPLE_RATE    = 44100,
  parameter int ACC_W          = clogb2(AUDIO_CLK_RATE) + 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic fr_tick_o
);

  localparam logic [ACC_W:0] STEP = (ACC_W + 1)'(SAMPLE_RATE);
  localparam logic [ACC_W:0] WRAP = (ACC_W + 1)'(AUDIO_CLK_RATE);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum;

  // One spare bit on the sum so the wrap compare cannot alias.
  always_comb begin
    sum       = {1'b0, acc_q} + STEP;
    fr_tick_o = (sum >= WRAP);
    acc_d     = fr_tick_o ? ACC_W'(sum - WRAP) : ACC_W'(sum);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/synth_sample_trig.sv
// Per-sample trig generator: free-run divider or codec LRCK source with automatic fallback,
// plus frame tracking against the engine's index-zero flag and overrun statistics.
module synth_sample_trig
  import synth_sample_trig_pkg::*;
#(
  parameter int AUDIO_CLK_RATE = 90416666,
  parameter int SAMPLE_RATE    = 44100,
  parameter int TRIG_W         = 4,
  parameter int LRCK_TIMEOUT   = 4096,
  parameter int ACC_W          = clogb2(AUDIO_CLK_RATE) + 1
) (
  input logic AUDIO_CLK,
  input logic reset_reg_N,
  synth_sample_trig_if.slave bus
);

  localparam int TO_W = clogb2(LRCK_TIMEOUT + 1);
  localparam int TW_W = clogb2(TRIG_W + 1);
  localparam logic [TO_W-1:0]      TO_MAX    = TO_W'(LRCK_TIMEOUT);
  localparam logic [TW_W-1:0]      TRIG_LOAD = TW_W'(TRIG_W);
  localparam logic [OVR_CNT_W-1:0] CNT_MAX   = '1;

  logic lrck_s1_q, lrck_s2_q, lrck_s3_q;
  logic zero_s1_q, zero_s2_q, zero_s3_q;
  logic lrck_rise, zero_rise;
  logic fr_tick;

  lock_state_e          lock_state_q;
  logic [TO_W-1:0]      to_cnt_q;
  frame_state_e         frame_state_q;
  logic [TW_W-1:0]      trig_cnt_q, trig_cnt_d;
  logic                 trig_q;
  logic                 ovr_q;
  logic [OVR_CNT_W-1:0] ovr_cnt_q;

  logic go_lock, use_lrck, sev, ovr_evt;

  // Stage 3 only holds the previous synchronized level for edge detection.
  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      lrck_s1_q <= 1'b0;
      lrck_s2_q <= 1'b0;
      lrck_s3_q <= 1'b0;
      zero_s1_q <= 1'b0;
      zero_s2_q <= 1'b0;
      zero_s3_q <= 1'b0;
    end else begin
      lrck_s1_q <= bus.lrck_in;
      lrck_s2_q <= lrck_s1_q;
      lrck_s3_q <= lrck_s2_q;
      zero_s1_q <= bus.xxxx_zero;
      zero_s2_q <= zero_s1_q;
      zero_s3_q <= zero_s2_q;
    end
  end

  assign lrck_rise = lrck_s2_q & ~lrck_s3_q;
  assign zero_rise = zero_s2_q & ~zero_s3_q;

  frac_tick_div #(
    .AUDIO_CLK_RATE(AUDIO_CLK_RATE),
    .SAMPLE_RATE   (SAMPLE_RATE),
    .ACC_W         (ACC_W)
  ) u_div (
    .clk_i    (AUDIO_CLK),
    .rst_ni   (reset_reg_N),
    .fr_tick_o(fr_tick)
  );

  // The locking edge itself is the sample event; a coincident divider tick is dropped.
  assign go_lock  = (lock_state_q == FREE) && bus.lock_en && lrck_rise;
  assign use_lrck = (lock_state_q == LOCKED) || go_lock;
  assign sev      = use_lrck ? lrck_rise : fr_tick;

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      lock_state_q <= FREE;
      to_cnt_q     <= '0;
    end else begin
      if (lrck_rise) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != TO_MAX) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      case (lock_state_q)
        FREE:    if (go_lock) lock_state_q <= LOCKED;
        LOCKED:  if (!bus.lock_en || (to_cnt_q == TO_MAX && !lrck_rise)) lock_state_q <= FREE;
        default: lock_state_q <= FREE;
      endcase
    end
  end

  always_comb begin
    trig_cnt_d = trig_cnt_q;
    if (sev && !trig_q) begin
      trig_cnt_d = TRIG_LOAD;
    end else if (trig_cnt_q != '0) begin
      trig_cnt_d = trig_cnt_q - TW_W'(1);
    end
  end

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      trig_cnt_q <= '0;
      trig_q     <= 1'b0;
    end else begin
      trig_cnt_q <= trig_cnt_d;
      trig_q     <= (trig_cnt_d != '0);
    end
  end

  // A frame ending in the same cycle a new one starts is a clean handover, not an overrun.
  assign ovr_evt = sev && (trig_q || (frame_state_q == BUSY && !zero_rise));

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      frame_state_q <= IDLE;
      ovr_q         <= 1'b0;
      ovr_cnt_q     <= '0;
    end else begin
      case (frame_state_q)
        IDLE:    if (sev) frame_state_q <= BUSY;
        BUSY:    if (zero_rise && !sev) frame_state_q <= IDLE;
        default: frame_state_q <= IDLE;
      endcase
      if (bus.clr_stat) begin
        ovr_q     <= 1'b0;
        ovr_cnt_q <= '0;
      end else if (ovr_evt) begin
        ovr_q <= 1'b1;
        if (ovr_cnt_q != CNT_MAX) begin
          ovr_cnt_q <= ovr_cnt_q + OVR_CNT_W'(1);
        end
      end
    end
  end

  assign bus.trig            = trig_q;
  assign bus.lrck_locked     = (lock_state_q == LOCKED);
  assign bus.frame_busy      = (frame_state_q == BUSY);
  assign bus.overrun         = ovr_q;
  assign bus.overrun_cnt     = ovr_cnt_q;
  assign bus.dbg_lock_state  = lock_state_q;
  assign bus.dbg_frame_state = frame_state_q;

endmodule
